// File: rtl/rect_draw_engine_if.sv
// ---------------------------------------------------------------------------
// rect_draw_engine_if
// Pixel write channel between the rectangle draw engine and layer memory.
//   wr_valid  engine -> memory  a pixel write is being presented
//   wr_ready  memory -> engine  the presented write is accepted this cycle
//   wr_x      engine -> memory  write column
//   wr_y      engine -> memory  write row
//   wr_color  engine -> memory  RGB colour {r,g,b}
//   wr_layer  engine -> memory  target layer mask {l3,l2,l1}
// ---------------------------------------------------------------------------
interface rect_draw_engine_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_color;
  logic [2:0] wr_layer;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, wr_layer,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, wr_layer,
    output wr_ready
  );
endinterface

// File: rtl/rect_draw_engine.sv
// ---------------------------------------------------------------------------
// rect_draw_engine
// Records two rectangle corners from a cursor and draws the rectangle outline
// as a stream of single-pixel writes.
//   clk_100MHz      sole clock, rising edge
//   reset           synchronous, active-low
//   cursor_x/y      current cursor position
//   record_rect_pt  rising edge stores corner A, falling edge stores corner B
//   draw_rectangle  rising edge starts drawing (needs both corners)
//   color, layer_en sampled when drawing starts
//   wr              pixel write channel (master side)
//   busy            high while drawing
//   done            one-cycle pulse after the last pixel is accepted
//   rect_state_led  current state code
// Pixel order: top row, bottom row, left column, right column; degenerate
// rectangles skip rows/columns that would repeat a pixel.
// ---------------------------------------------------------------------------
module rect_draw_engine #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [9:0]          cursor_x,
  input  logic [9:0]          cursor_y,
  input  logic                record_rect_pt,
  input  logic                draw_rectangle,
  input  logic [2:0]          color,
  input  logic [2:0]          layer_en,
  rect_draw_engine_if.master  wr,
  output logic                busy,
  output logic                done,
  output logic [1:0]          rect_state_led
);

  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HAVE_A  = 2'b01,
    HAVE_AB = 2'b10,
    DRAW    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SEG_TOP,
    SEG_BOT,
    SEG_LEFT,
    SEG_RIGHT
  } seg_t;

  state_t     state, state_n;
  seg_t       seg, seg_n;
  logic [9:0] ax, ay, bx, by, ax_n, ay_n, bx_n, by_n;
  logic [9:0] x0, x1, y0, y1, x0_n, x1_n, y0_n, y1_n;
  logic [9:0] cur_x, cur_y, cur_x_n, cur_y_n;
  logic [2:0] col_r, lay_r, col_n, lay_n;
  logic       rec_q, draw_q;
  logic       done_r, done_n;
  logic       last;

  wire rec_rise  = record_rect_pt & ~rec_q;
  wire rec_fall  = ~record_rect_pt & rec_q;
  wire draw_rise = draw_rectangle & ~draw_q;
  wire hs        = wr.wr_valid & wr.wr_ready;

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_n = state;
    seg_n   = seg;
    ax_n    = ax;
    ay_n    = ay;
    bx_n    = bx;
    by_n    = by;
    x0_n    = x0;
    x1_n    = x1;
    y0_n    = y0;
    y1_n    = y1;
    cur_x_n = cur_x;
    cur_y_n = cur_y;
    col_n   = col_r;
    lay_n   = lay_r;
    done_n  = 1'b0;
    last    = 1'b0;

    unique case (state)
      IDLE: begin
        if (rec_rise) begin
          ax_n    = clamp(cursor_x, X_MAX);
          ay_n    = clamp(cursor_y, Y_MAX);
          state_n = HAVE_A;
        end
      end

      HAVE_A: begin
        if (rec_fall) begin
          bx_n    = clamp(cursor_x, X_MAX);
          by_n    = clamp(cursor_y, Y_MAX);
          state_n = HAVE_AB;
        end
      end

      HAVE_AB: begin
        if (rec_rise) begin
          // Re-recording starts a fresh rectangle; the old B is dropped.
          ax_n    = clamp(cursor_x, X_MAX);
          ay_n    = clamp(cursor_y, Y_MAX);
          bx_n    = '0;
          by_n    = '0;
          state_n = HAVE_A;
        end else if (draw_rise && layer_en != 3'b000) begin
          x0_n    = (ax < bx) ? ax : bx;
          x1_n    = (ax < bx) ? bx : ax;
          y0_n    = (ay < by) ? ay : by;
          y1_n    = (ay < by) ? by : ay;
          cur_x_n = (ax < bx) ? ax : bx;
          cur_y_n = (ay < by) ? ay : by;
          seg_n   = SEG_TOP;
          col_n   = color;
          lay_n   = layer_en;
          state_n = DRAW;
        end
      end

      DRAW: begin
        if (hs) begin
          unique case (seg)
            SEG_TOP: begin
              if (cur_x != x1) begin
                cur_x_n = cur_x + 10'd1;
              end else if (y0 != y1) begin
                seg_n   = SEG_BOT;
                cur_x_n = x0;
                cur_y_n = y1;
              end else begin
                last = 1'b1;
              end
            end
            SEG_BOT: begin
              // Columns exist only when there is a row strictly between y0 and y1.
              if (cur_x != x1) begin
                cur_x_n = cur_x + 10'd1;
              end else if ((y1 - y0) >= 10'd2) begin
                seg_n   = SEG_LEFT;
                cur_x_n = x0;
                cur_y_n = y0 + 10'd1;
              end else begin
                last = 1'b1;
              end
            end
            SEG_LEFT: begin
              if (cur_y != y1 - 10'd1) begin
                cur_y_n = cur_y + 10'd1;
              end else if (x0 != x1) begin
                seg_n   = SEG_RIGHT;
                cur_x_n = x1;
                cur_y_n = y0 + 10'd1;
              end else begin
                last = 1'b1;
              end
            end
            SEG_RIGHT: begin
              if (cur_y != y1 - 10'd1) begin
                cur_y_n = cur_y + 10'd1;
              end else begin
                last = 1'b1;
              end
            end
            default: last = 1'b1;
          endcase
          if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state  <= IDLE;
      seg    <= SEG_TOP;
      ax     <= '0;
      ay     <= '0;
      bx     <= '0;
      by     <= '0;
      x0     <= '0;
      x1     <= '0;
      y0     <= '0;
      y1     <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      col_r  <= '0;
      lay_r  <= '0;
      done_r <= 1'b0;
      // Cleared so a switch already high at reset release reads as a rising edge.
      rec_q  <= 1'b0;
      draw_q <= 1'b0;
    end else begin
      state  <= state_n;
      seg    <= seg_n;
      ax     <= ax_n;
      ay     <= ay_n;
      bx     <= bx_n;
      by     <= by_n;
      x0     <= x0_n;
      x1     <= x1_n;
      y0     <= y0_n;
      y1     <= y1_n;
      cur_x  <= cur_x_n;
      cur_y  <= cur_y_n;
      col_r  <= col_n;
      lay_r  <= lay_n;
      done_r <= done_n;
      rec_q  <= record_rect_pt;
      draw_q <= draw_rectangle;
    end
  end

  assign wr.wr_valid    = (state == DRAW);
  assign wr.wr_x        = cur_x;
  assign wr.wr_y        = cur_y;
  assign wr.wr_color    = col_r;
  assign wr.wr_layer    = lay_r;
  assign busy           = (state == DRAW);
  assign done           = done_r;
  assign rect_state_led = state;

endmodule
